// File: rtl/mem_arbiter.sv
// Byte-wide RAM port sequencer shared by instruction fetch and MEM-stage load/store.
// Latency: read done N+1 edges after accept, write done N edges after accept (N = 1/2/4 bytes).
// Backpressure: one transaction at a time; busy is high while a transaction is in flight, requests wait in IDLE.
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   if_req/if_addr         fetch request (always 4 bytes)
//   if_done/if_inst        one-cycle completion pulse and assembled little-endian instruction
//   flush                  aborts an in-flight fetch, blocks fetch acceptance in IDLE
//   mem_req/we/len/addr/wdata   data access request (byte/half/word)
//   mem_done/mem_rdata     one-cycle completion pulse and zero-extended load data
//   ram_a/ram_dout/ram_wr  RAM byte address, write byte, write strobe
//   ram_din                RAM read byte, valid one cycle after ram_a
//   busy                   high whenever the sequencer is not idle
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              flush,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IF_RD  = 2'd1;
  localparam logic [1:0] MEM_RD = 2'd2;
  localparam logic [1:0] MEM_WR = 2'd3;

  logic [1:0]        state_q,     state_d;
  // cnt_q counts edges since accept: in a read it is both the index of the
  // address being presented (cnt_q) and, one behind, the byte being captured.
  logic [2:0]        cnt_q,       cnt_d;
  logic [2:0]        nbytes_q,    nbytes_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [31:0]       wdata_q,     wdata_d;
  logic [31:0]       rbuf_q,      rbuf_d;
  logic [ADDR_W-1:0] ram_a_q,     ram_a_d;
  logic [7:0]        ram_dout_q,  ram_dout_d;
  logic              ram_wr_q,    ram_wr_d;
  logic              if_done_q,   if_done_d;
  logic [31:0]       if_inst_q,   if_inst_d;
  logic              mem_done_q,  mem_done_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              busy_q,      busy_d;

  logic [2:0]        next_idx;
  logic [ADDR_W-1:0] next_addr;
  logic [31:0]       rbuf_cap;
  logic [7:0]        wbyte;
  logic [2:0]        len_n;

  always_comb begin
    next_idx  = cnt_q + 3'd1;
    next_addr = addr_q + ADDR_W'(next_idx);

    // Read buffer with the byte arriving this cycle merged in; byte cnt_q-1
    // is on ram_din because its address went out one cycle earlier.
    rbuf_cap = rbuf_q;
    case (cnt_q)
      3'd1:    rbuf_cap[7:0]   = ram_din;
      3'd2:    rbuf_cap[15:8]  = ram_din;
      3'd3:    rbuf_cap[23:16] = ram_din;
      3'd4:    rbuf_cap[31:24] = ram_din;
      default: rbuf_cap        = rbuf_q;
    endcase

    case (next_idx)
      3'd1:    wbyte = wdata_q[15:8];
      3'd2:    wbyte = wdata_q[23:16];
      3'd3:    wbyte = wdata_q[31:24];
      default: wbyte = wdata_q[7:0];
    endcase

    case (mem_len)
      2'b00:   len_n = 3'd1;
      2'b01:   len_n = 3'd2;
      default: len_n = 3'd4;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nbytes_d    = nbytes_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = ram_wr_q;
    if_done_d   = 1'b0;
    if_inst_d   = if_inst_q;
    mem_done_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      IDLE: begin
        ram_wr_d = 1'b0;
        if (mem_req) begin
          addr_d   = mem_addr;
          wdata_d  = mem_wdata;
          nbytes_d = len_n;
          cnt_d    = 3'd0;
          rbuf_d   = 32'd0;
          ram_a_d  = mem_addr;
          if (mem_we) begin
            state_d    = MEM_WR;
            ram_dout_d = mem_wdata[7:0];
            ram_wr_d   = 1'b1;
          end else begin
            state_d    = MEM_RD;
          end
        end else if (if_req && !flush) begin
          addr_d   = if_addr;
          nbytes_d = 3'd4;
          cnt_d    = 3'd0;
          rbuf_d   = 32'd0;
          ram_a_d  = if_addr;
          state_d  = IF_RD;
        end
      end

      IF_RD, MEM_RD: begin
        if (state_q == IF_RD && flush) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          if (next_idx < nbytes_q) begin
            ram_a_d = next_addr;
          end
          if (cnt_q != 3'd0) begin
            rbuf_d = rbuf_cap;
          end
          if (cnt_q == nbytes_q) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            if (state_q == IF_RD) begin
              if_done_d   = 1'b1;
              if_inst_d   = rbuf_cap;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = rbuf_cap;
            end
          end else begin
            cnt_d = next_idx;
          end
        end
      end

      MEM_WR: begin
        if (next_idx < nbytes_q) begin
          ram_a_d    = next_addr;
          ram_dout_d = wbyte;
          cnt_d      = next_idx;
        end else begin
          ram_wr_d   = 1'b0;
          mem_done_d = 1'b1;
          state_d    = IDLE;
          cnt_d      = 3'd0;
        end
      end

      default: begin
        state_d  = IDLE;
        ram_wr_d = 1'b0;
        cnt_d    = 3'd0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      nbytes_q    <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      rbuf_q      <= 32'd0;
      ram_a_q     <= '0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      if_inst_q   <= 32'd0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= 32'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nbytes_q    <= nbytes_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      if_inst_q   <= if_inst_d;
      mem_done_q  <= mem_done_d;
      mem_rdata_q <= mem_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q;
  assign if_done   = if_done_q;
  assign if_inst   = if_inst_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a byte RAM with one-cycle read latency, plus a reference
// memory image and expected outputs derived from transaction-level rules.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_req, if_done, flush, mem_req, mem_we, mem_done, ram_wr, busy;
  logic [31:0] if_addr, if_inst, mem_addr, mem_wdata, mem_rdata, ram_a;
  logic [1:0]  mem_len;
  logic [7:0]  ram_dout, ram_din;

  logic [7:0]  ram [1024];
  logic [7:0]  ref_mem [1024];
  logic        init_ram, poke_en;
  logic [9:0]  poke_addr;
  logic [7:0]  poke_dat;

  int          n_tests, n_fail;
  logic [31:0] exp_if_inst, exp_mem_rdata;
  bit          rdata_known;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din),
    .busy(busy)
  );

  // RAM: write on ram_wr, read data registered (valid one cycle after ram_a).
  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'(i * 37 + 11);
    end else if (poke_en) begin
      ram[poke_addr] <= poke_dat;
    end else if (ram_wr) begin
      ram[ram_a[9:0]] <= ram_dout;
    end
    ram_din <= ram[ram_a[9:0]];
  end

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk); poke_en = 1'b1; poke_addr = a; poke_dat = d;
    @(posedge clk);
    @(negedge clk); poke_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Drives one transaction and checks address sequence, strobes, done timing and data.
  task automatic xact(input bit is_if, input bit we, input logic [1:0] len,
                      input logic [31:0] addr, input logic [31:0] wdata, input bit hold_flush);
    int n, edges, cycle;
    bit seen;
    logic [31:0] exp_rd, sh;
    n = is_if ? 4 : (len == 2'b00 ? 1 : (len == 2'b01 ? 2 : 4));
    exp_rd = 32'd0;
    for (int k = 0; k < n; k++) exp_rd |= {24'd0, ref_mem[10'(addr + 32'(k))]} << (8 * k);
    @(negedge clk);
    if (is_if) begin if_req = 1'b1; if_addr = addr; end
    else begin mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata; end
    flush = hold_flush;
    @(posedge clk);
    @(negedge clk);
    if_req = 1'b0; mem_req = 1'b0;
    if_addr = $urandom; mem_addr = $urandom; mem_wdata = $urandom;
    mem_len = 2'($urandom); mem_we = 1'($urandom);
    edges = 0; seen = 1'b0;
    while (!seen && edges <= n + 3) begin
      cycle = edges + 1;
      if (cycle <= n) begin
        n_tests++;
        if (ram_a !== addr + 32'(cycle - 1)) begin
          n_fail++; $display("FAIL xact_ram_a cycle %0d: got %h expected %h", cycle, ram_a, addr + 32'(cycle - 1));
        end
        if (we) begin
          sh = wdata >> (8 * (cycle - 1));
          n_tests++;
          if (ram_dout !== sh[7:0]) begin
            n_fail++; $display("FAIL xact_ram_dout cycle %0d: got %h expected %h", cycle, ram_dout, sh[7:0]);
          end
        end
      end
      n_tests++;
      if (ram_wr !== (we && cycle <= n)) begin
        n_fail++; $display("FAIL xact_ram_wr cycle %0d: got %b expected %b", cycle, ram_wr, (we && cycle <= n));
      end
      @(posedge clk); edges++;
      @(negedge clk);
      seen = is_if ? if_done : mem_done;
      n_tests++;
      if ((is_if ? mem_done : if_done) !== 1'b0) begin
        n_fail++; $display("FAIL xact_wrong_done: got 1 expected 0");
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++; $display("FAIL xact_timeout: no done within %0d edges", edges);
    end else if (edges != (we ? n : n + 1)) begin
      n_fail++; $display("FAIL xact_latency: got %0d edges expected %0d", edges, (we ? n : n + 1));
    end
    n_tests++;
    if (busy !== 1'b0 || ram_wr !== 1'b0) begin
      n_fail++; $display("FAIL xact_done_cycle: busy %b ram_wr %b expected 0 0", busy, ram_wr);
    end
    if (is_if) exp_if_inst = exp_rd;
    else if (!we) begin exp_mem_rdata = exp_rd; rdata_known = 1'b1; end
    else begin
      for (int k = 0; k < n; k++) ref_mem[10'(addr + 32'(k))] = wdata[8 * k +: 8];
      rdata_known = 1'b0;
    end
    n_tests++;
    if (if_inst !== exp_if_inst) begin
      n_fail++; $display("FAIL xact_if_inst: got %h expected %h", if_inst, exp_if_inst);
    end
    if (rdata_known) begin
      n_tests++;
      if (mem_rdata !== exp_mem_rdata) begin
        n_fail++; $display("FAIL xact_mem_rdata: got %h expected %h", mem_rdata, exp_mem_rdata);
      end
    end
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    n_tests++;
    if (if_done !== 1'b0 || mem_done !== 1'b0) begin
      n_fail++; $display("FAIL xact_pulse_width: if_done %b mem_done %b expected 0 0", if_done, mem_done);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; init_ram = 1'b1; poke_en = 1'b0; poke_addr = '0; poke_dat = '0;
    if_req = 0; if_addr = 0; flush = 0; mem_req = 0; mem_we = 0; mem_len = 0; mem_addr = 0; mem_wdata = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 37 + 11);
    exp_if_inst = 32'd0; exp_mem_rdata = 32'd0; rdata_known = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init_ram = 1'b0;
    n_tests++;
    if ({if_done, mem_done, ram_wr, busy} !== 4'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {if_done, mem_done, ram_wr, busy});
    end
    n_tests++;
    if ({if_inst, mem_rdata, ram_a, ram_dout} !== 104'd0) begin
      n_fail++; $display("FAIL reset_data: if_inst %h mem_rdata %h ram_a %h ram_dout %h expected 0", if_inst, mem_rdata, ram_a, ram_dout);
    end
    rst = 1'b1;
  endtask

  task automatic test_fetch;
    poke(10'h100, 8'h13); poke(10'h101, 8'h05); poke(10'h102, 8'h00); poke(10'h103, 8'h00);
    xact(1'b1, 1'b0, 2'b10, 32'h100, 32'd0, 1'b0);
    n_tests++;
    if (if_inst !== 32'h0000_0513) begin
      n_fail++; $display("FAIL fetch_0x100: got %h expected 00000513", if_inst);
    end
  endtask

  task automatic test_priority;
    int edges;
    logic [31:0] w, exp_i;
    w = 32'hDEAD_BEEF;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h20; mem_wdata = w;
    @(posedge clk);
    @(negedge clk);
    mem_req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_tests++;
      if (ram_wr !== 1'b1 || ram_a !== 32'h20 + 32'(c - 1) || ram_dout !== w[8 * (c - 1) +: 8] || if_done !== 1'b0) begin
        n_fail++; $display("FAIL prio_store cycle %0d: wr %b a %h dout %h if_done %b expected 1 %h %h 0",
                           c, ram_wr, ram_a, ram_dout, if_done, 32'h20 + 32'(c - 1), w[8 * (c - 1) +: 8]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    n_tests++;
    if (mem_done !== 1'b1 || ram_wr !== 1'b0) begin
      n_fail++; $display("FAIL prio_store_done: mem_done %b ram_wr %b expected 1 0", mem_done, ram_wr);
    end
    for (int k = 0; k < 4; k++) ref_mem[10'(32'h20 + 32'(k))] = w[8 * k +: 8];
    rdata_known = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if_req = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || ram_a !== 32'h0) begin
      n_fail++; $display("FAIL prio_fetch_accept: busy %b ram_a %h expected 1 00000000", busy, ram_a);
    end
    exp_i = {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]};
    edges = 0;
    while (if_done !== 1'b1 && edges < 10) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
    n_tests++;
    if (edges != 5 || if_inst !== exp_i) begin
      n_fail++; $display("FAIL prio_fetch_done: edges %0d inst %h expected 5 %h", edges, if_inst, exp_i);
    end
    exp_if_inst = exp_i;
  endtask

  task automatic test_flush;
    int edges;
    bit bad;
    logic [31:0] exp_i;
    @(negedge clk); if_req = 1'b1; if_addr = 32'h8;
    @(posedge clk); @(negedge clk); if_req = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk); flush = 1'b1;
    @(posedge clk); @(negedge clk); flush = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || if_done !== 1'b0) begin
      n_fail++; $display("FAIL flush_abort: busy %b if_done %b expected 0 0", busy, if_done);
    end
    bad = 1'b0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (if_done !== 1'b0 || busy !== 1'b0 || ram_wr !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad || if_inst !== exp_if_inst) begin
      n_fail++; $display("FAIL flush_quiet: activity %b inst %h expected 0 %h", bad, if_inst, exp_if_inst);
    end
    xact(1'b1, 1'b0, 2'b10, 32'hC, 32'd0, 1'b0);

    // flush while idle holds off a fetch request for that edge
    @(negedge clk); if_req = 1'b1; if_addr = 32'h10; flush = 1'b1;
    @(posedge clk); @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle_block: busy %b expected 0", busy);
    end
    flush = 1'b0;
    @(posedge clk); @(negedge clk); if_req = 1'b0;
    exp_i = {ref_mem[10'h13], ref_mem[10'h12], ref_mem[10'h11], ref_mem[10'h10]};
    edges = 0;
    while (if_done !== 1'b1 && edges < 10) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
    n_tests++;
    if (edges != 5 || if_inst !== exp_i) begin
      n_fail++; $display("FAIL flush_idle_fetch: edges %0d inst %h expected 5 %h", edges, if_inst, exp_i);
    end
    exp_if_inst = exp_i;
    // flush has no effect on data accesses
    xact(1'b0, 1'b0, 2'b10, 32'h44, 32'd0, 1'b1);
    xact(1'b0, 1'b1, 2'b10, 32'h48, $urandom, 1'b1);
    xact(1'b0, 1'b0, 2'b10, 32'h48, 32'd0, 1'b1);
  endtask

  task automatic test_load_store;
    poke(10'h31, 8'h80); poke(10'h30, 8'h34);
    xact(1'b0, 1'b0, 2'b00, 32'h31, 32'd0, 1'b0);
    n_tests++;
    if (mem_rdata !== 32'h0000_0080) begin
      n_fail++; $display("FAIL load_byte: got %h expected 00000080", mem_rdata);
    end
    xact(1'b0, 1'b0, 2'b01, 32'h30, 32'd0, 1'b0);
    n_tests++;
    if (mem_rdata !== 32'h0000_8034) begin
      n_fail++; $display("FAIL load_half: got %h expected 00008034", mem_rdata);
    end
    poke(10'h42, 8'h5A);
    xact(1'b0, 1'b1, 2'b01, 32'h40, 32'hABCD_1234, 1'b0);
    n_tests++;
    if ({ram[10'h42], ram[10'h41], ram[10'h40]} !== 24'h5A1234) begin
      n_fail++; $display("FAIL store_half: got %h expected 5a1234", {ram[10'h42], ram[10'h41], ram[10'h40]});
    end
    // len 11 behaves as a word
    xact(1'b0, 1'b1, 2'b11, 32'h50, 32'h0BAD_CAFE, 1'b0);
    xact(1'b0, 1'b0, 2'b11, 32'h50, 32'd0, 1'b0);
    n_tests++;
    if (mem_rdata !== 32'h0BAD_CAFE) begin
      n_fail++; $display("FAIL len11_word: got %h expected 0badcafe", mem_rdata);
    end
    // address wrap past 2^32
    xact(1'b0, 1'b1, 2'b10, 32'hFFFF_FFFE, 32'h7654_3210, 1'b0);
    xact(1'b1, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'd0, 1'b0);
    n_tests++;
    if (if_inst !== 32'h7654_3210) begin
      n_fail++; $display("FAIL wrap_fetch: got %h expected 76543210", if_inst);
    end
  endtask

  task automatic test_back_to_back;
    bit exp_done [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bit exp_busy [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    @(negedge clk); mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h77;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 4) mem_req = 1'b0;
      n_tests++;
      if (mem_done !== exp_done[c - 1] || busy !== exp_busy[c - 1]) begin
        n_fail++; $display("FAIL b2b cycle %0d: done %b busy %b expected %b %b", c, mem_done, busy, exp_done[c - 1], exp_busy[c - 1]);
      end
      if (c < 6) @(posedge clk);
    end
    exp_mem_rdata = {24'd0, ref_mem[10'h77]}; rdata_known = 1'b1;
    n_tests++;
    if (mem_rdata !== exp_mem_rdata) begin
      n_fail++; $display("FAIL b2b_data: got %h expected %h", mem_rdata, exp_mem_rdata);
    end
  endtask

  task automatic test_reset_mid;
    bit bad;
    @(negedge clk); if_req = 1'b1; if_addr = 32'h200;
    @(posedge clk); @(negedge clk); if_req = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if ({if_done, mem_done, ram_wr, busy} !== 4'b0) begin
      n_fail++; $display("FAIL rstmid_strobes: got %b expected 0000", {if_done, mem_done, ram_wr, busy});
    end
    n_tests++;
    if ({if_inst, mem_rdata, ram_a, ram_dout} !== 104'd0) begin
      n_fail++; $display("FAIL rstmid_data: if_inst %h mem_rdata %h ram_a %h ram_dout %h expected 0", if_inst, mem_rdata, ram_a, ram_dout);
    end
    @(negedge clk); rst = 1'b1;
    exp_if_inst = 32'd0; exp_mem_rdata = 32'd0; rdata_known = 1'b1;
    bad = 1'b0;
    repeat (8) begin
      @(posedge clk); @(negedge clk);
      if (if_done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL rstmid_no_done: activity after release got 1 expected 0");
    end
    xact(1'b1, 1'b0, 2'b10, 32'h204, 32'd0, 1'b0);
  endtask

  task automatic test_random;
    int kind;
    logic [31:0] a;
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 2);
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 1023));
      if (kind == 0) xact(1'b1, 1'b0, 2'b10, a, 32'd0, 1'b0);
      else xact(1'b0, kind == 2, 2'($urandom_range(0, 3)), a, $urandom, 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    int bad_bytes;
    n_tests = 0; n_fail = 0;
    test_reset;
    test_fetch;
    test_priority;
    test_flush;
    test_load_store;
    test_back_to_back;
    test_reset_mid;
    test_random;
    @(negedge clk);
    bad_bytes = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) bad_bytes++;
    n_tests++;
    if (bad_bytes != 0) begin
      n_fail++; $display("FAIL ram_image: %0d bytes differ, expected 0", bad_bytes);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
